cp_cmd_dispatcher: RTL and testbench



---
 rtl/cp_cmd_pkg.sv | 41 ++++
 rtl/cp_cmd_dispatcher_if.sv | 32 +++
 rtl/cp_ack_timer.sv | 26 ++
 rtl/cp_cmd_dispatcher.sv | 155 +++++++++++++++
 tb/tb_cp_cmd_dispatcher.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_cmd_pkg.sv
// Shared types and constants for the control-plane command dispatcher.
package cp_cmd_pkg;

   localparam int unsigned CMD_W     = 128;
   localparam int unsigned OPC_LSB   = 0;
   localparam int unsigned TGT_LSB   = 8;
   localparam int unsigned RSVD_LSB  = 16;
   localparam int unsigned ADDR_LSB  = 32;
   localparam int unsigned WDATA_LSB = 64;

   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;

   localparam logic [7:0] ST_OK      = 8'h80;
   localparam logic [7:0] ST_TIMEOUT = 8'h81;
   localparam logic [7:0] ST_BADTGT  = 8'h82;
   localparam logic [7:0] ST_BADOP   = 8'h83;

   localparam logic [1:0]  BANK_DATA    = 2'b11;
   localparam logic [1:0]  BANK_CMD     = 2'b10;
   localparam logic [63:0] WB_STAT_MASK = 64'h00000000_FF000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_REQ,
      S_WB_DATA,
      S_WB_STAT,
      S_DONE
   } state_t;

   // Field order matches the COMM_DATA bit layout (MSB first).
   typedef struct packed {
      logic [63:0] wdata;
      logic [31:0] addr;
      logic [15:0] rsvd;
      logic [7:0]  target;
      logic [7:0]  opcode;
   } cmd_t;

endpackage

// File: rtl/cp_cmd_dispatcher_if.sv
// Register-interface and target-bus signals of the command dispatcher.
interface cp_cmd_dispatcher_if #(
   parameter int unsigned N_TGT = 4
);
   logic                  COMM_VALID;
   logic [127:0]          COMM_DATA;
   logic                  DATA_VALID;
   logic [63:0]           DATA_RBACK;
   logic [63:0]           DATA_MASK;
   logic [1:0]            DATA_OFFSET;
   logic [N_TGT-1:0]      TGT_REQ;
   logic                  TGT_WE;
   logic [31:0]           TGT_ADDR;
   logic [63:0]           TGT_WDATA;
   logic [N_TGT-1:0]      TGT_ACK;
   logic [N_TGT*64-1:0]   TGT_RDATA;
   logic                  BUSY;

   // Dispatcher side.
   modport master (
      input  COMM_VALID, COMM_DATA, TGT_ACK, TGT_RDATA,
      output DATA_VALID, DATA_RBACK, DATA_MASK, DATA_OFFSET,
      output TGT_REQ, TGT_WE, TGT_ADDR, TGT_WDATA, BUSY
   );

   // Register interface plus targets.
   modport slave (
      output COMM_VALID, COMM_DATA, TGT_ACK, TGT_RDATA,
      input  DATA_VALID, DATA_RBACK, DATA_MASK, DATA_OFFSET,
      input  TGT_REQ, TGT_WE, TGT_ADDR, TGT_WDATA, BUSY
   );
endinterface

// File: rtl/cp_ack_timer.sv
// Acknowledge timeout counter: load clears, enable counts, saturates at TIMEOUT-1.
module cp_ack_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic SYS_CLK,
   input  logic RST,
   input  logic load,
   input  logic en,
   output logic expired_c
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (en && !expired_c) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/cp_cmd_dispatcher.sv
// Control-plane command sequencer: decodes a host command, runs one target
// transaction with timeout, and writes data/status back to the register file.
module cp_cmd_dispatcher
   import cp_cmd_pkg::*;
#(
   parameter int unsigned N_TGT   = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             SYS_CLK,
   input  logic             RST,
   cp_cmd_dispatcher_if.master bus
);
   state_t           state;
   logic             comm_valid_q;
   cmd_t             cmd_q;
   logic [7:0]       status_q;
   logic [N_TGT-1:0] tgt_req_q;
   logic             tgt_we_q;
   logic [31:0]      tgt_addr_q;
   logic [63:0]      tgt_wdata_q;
   logic [63:0]      rdata_q;
   logic             data_valid_q;
   logic [63:0]      data_rback_q;
   logic [63:0]      data_mask_q;
   logic [1:0]       data_offset_q;
   logic             busy_q;

   logic             trigger_c;
   logic             ack_hit_c;
   logic [63:0]      rdata_sel_c;
   logic             timer_load_c;
   logic             timer_en_c;
   logic             timer_expired_c;
   logic             unused_rsvd_c;

   assign trigger_c     = bus.COMM_VALID && !comm_valid_q;
   // Request is one-hot, so masking with it ignores acks from other targets.
   assign ack_hit_c     = |(bus.TGT_ACK & tgt_req_q);
   assign timer_load_c  = (state == S_DECODE);
   assign timer_en_c    = (state == S_REQ);
   assign unused_rsvd_c = ^cmd_q.rsvd;

   // Read-data mux keyed by the active request line.
   always_comb begin
      rdata_sel_c = '0;
      for (int i = 0; i < int'(N_TGT); i++) begin
         if (tgt_req_q[i]) begin
            rdata_sel_c = bus.TGT_RDATA[i*64 +: 64];
         end
      end
   end

   cp_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .SYS_CLK   (SYS_CLK),
      .RST       (RST),
      .load      (timer_load_c),
      .en        (timer_en_c),
      .expired_c (timer_expired_c)
   );

   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         state         <= S_IDLE;
         comm_valid_q  <= 1'b0;
         cmd_q         <= '0;
         status_q      <= '0;
         tgt_req_q     <= '0;
         tgt_we_q      <= 1'b0;
         tgt_addr_q    <= '0;
         tgt_wdata_q   <= '0;
         rdata_q       <= '0;
         data_valid_q  <= 1'b0;
         data_rback_q  <= '0;
         data_mask_q   <= '0;
         data_offset_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         comm_valid_q  <= bus.COMM_VALID;
         data_valid_q  <= 1'b0;
         data_rback_q  <= '0;
         data_mask_q   <= '0;
         data_offset_q <= '0;
         case (state)
            S_IDLE: begin
               if (trigger_c) begin
                  cmd_q  <= cmd_t'(bus.COMM_DATA);
                  busy_q <= 1'b1;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (cmd_q.target >= 8'(N_TGT)) begin
                  status_q <= ST_BADTGT;
                  state    <= S_WB_STAT;
               end else if ((cmd_q.opcode != OP_READ) && (cmd_q.opcode != OP_WRITE)) begin
                  status_q <= ST_BADOP;
                  state    <= S_WB_STAT;
               end else begin
                  tgt_req_q   <= N_TGT'(1) << cmd_q.target;
                  tgt_we_q    <= (cmd_q.opcode == OP_WRITE);
                  tgt_addr_q  <= cmd_q.addr;
                  tgt_wdata_q <= cmd_q.wdata;
                  state       <= S_REQ;
               end
            end
            S_REQ: begin
               if (ack_hit_c) begin
                  tgt_req_q <= '0;
                  rdata_q   <= rdata_sel_c;
                  status_q  <= ST_OK;
                  state     <= tgt_we_q ? S_WB_STAT : S_WB_DATA;
               end else if (timer_expired_c) begin
                  tgt_req_q <= '0;
                  status_q  <= ST_TIMEOUT;
                  state     <= S_WB_STAT;
               end
            end
            S_WB_DATA: begin
               data_valid_q  <= 1'b1;
               data_offset_q <= BANK_DATA;
               data_mask_q   <= '1;
               data_rback_q  <= rdata_q;
               state         <= S_WB_STAT;
            end
            S_WB_STAT: begin
               data_valid_q  <= 1'b1;
               data_offset_q <= BANK_CMD;
               data_mask_q   <= WB_STAT_MASK;
               data_rback_q  <= {32'h0, status_q, 24'h0};
               state         <= S_DONE;
            end
            S_DONE: begin
               // Hold until the stop-condition level drops so it cannot re-issue.
               if (!bus.COMM_VALID) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.TGT_REQ     = tgt_req_q;
   assign bus.TGT_WE      = tgt_we_q;
   assign bus.TGT_ADDR    = tgt_addr_q;
   assign bus.TGT_WDATA   = tgt_wdata_q;
   assign bus.DATA_VALID  = data_valid_q;
   assign bus.DATA_RBACK  = data_rback_q;
   assign bus.DATA_MASK   = data_mask_q;
   assign bus.DATA_OFFSET = data_offset_q;
   assign bus.BUSY        = busy_q;
endmodule

// File: tb/tb_cp_cmd_dispatcher.sv
// Scoreboard bench for cp_cmd_dispatcher: expected writebacks are queued at
// issue time and popped by a monitor whenever DATA_VALID is seen.
module tb_cp_cmd_dispatcher;
   import cp_cmd_pkg::*;

   localparam int unsigned NT = 4;
   localparam int unsigned TO = 16;

   logic SYS_CLK = 1'b0;
   logic RST     = 1'b1;

   always #5 SYS_CLK = ~SYS_CLK;

   cp_cmd_dispatcher_if #(.N_TGT(NT)) bus ();

   cp_cmd_dispatcher #(.N_TGT(NT), .TIMEOUT(TO)) dut (
      .SYS_CLK (SYS_CLK),
      .RST     (RST),
      .bus     (bus.master)
   );

   typedef struct packed {
      logic [1:0]  off;
      logic [63:0] mask;
      logic [63:0] rb;
   } wb_t;

   wb_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge SYS_CLK);
      #1;
   endtask

   function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] tgt,
                                       input logic [31:0] a, input logic [63:0] wd);
      return {wd, a, 16'h0, tgt, op};
   endfunction

   task automatic push_data(input logic [63:0] rd);
      wb_t w;
      w.off  = 2'b11;
      w.mask = 64'hFFFFFFFF_FFFFFFFF;
      w.rb   = rd;
      exp_q.push_back(w);
   endtask

   task automatic push_stat(input logic [7:0] st);
      wb_t w;
      w.off  = 2'b10;
      w.mask = 64'h00000000_FF000000;
      w.rb   = {32'h0, st, 24'h0};
      exp_q.push_back(w);
   endtask

   task automatic issue(input logic [127:0] cmd);
      bus.COMM_DATA  = cmd;
      bus.COMM_VALID = 1'b1;
   endtask

   task automatic wait_req(input string name);
      int k = 0;
      while (bus.TGT_REQ == '0 && k < 20) begin
         step(1);
         k++;
      end
      chk({name, "_req_seen"}, 128'(bus.TGT_REQ != '0), 128'(1));
   endtask

   task automatic finish_txn(input string name);
      step(6);
      bus.COMM_VALID = 1'b0;
      step(2);
      chk({name, "_busy_clear"}, 128'(bus.BUSY), 128'(0));
      chk({name, "_wb_drained"}, 128'(exp_q.size()), 128'(0));
   endtask

   // Writeback monitor.
   always @(negedge SYS_CLK) begin
      wb_t e;
      if (!RST && bus.DATA_VALID) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_unexpected: offset %0d rback %0h, expected no writeback",
                     bus.DATA_OFFSET, bus.DATA_RBACK);
         end else begin
            e = exp_q.pop_front();
            chk("wb_offset", 128'(bus.DATA_OFFSET), 128'(e.off));
            chk("wb_mask",   128'(bus.DATA_MASK),   128'(e.mask));
            chk("wb_rback",  128'(bus.DATA_RBACK),  128'(e.rb));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int held;
      int cnt;
      int rises;
      logic prev;
      logic seen;

      bus.COMM_VALID = 1'b0;
      bus.COMM_DATA  = '0;
      bus.TGT_ACK    = '0;
      bus.TGT_RDATA  = '0;
      step(2);
      chk("rst_req",   128'(bus.TGT_REQ),    128'(0));
      chk("rst_busy",  128'(bus.BUSY),       128'(0));
      chk("rst_valid", 128'(bus.DATA_VALID), 128'(0));
      chk("rst_rback", 128'(bus.DATA_RBACK), 128'(0));
      RST = 1'b0;
      step(2);

      // READ target 2, ack after three held cycles.
      push_data(64'hDEADBEEF_01234567);
      push_stat(8'h80);
      issue(mk(8'h01, 8'd2, 32'h10, 64'h0));
      wait_req("rd");
      chk("rd_req",  128'(bus.TGT_REQ),  128'(4'b0100));
      chk("rd_we",   128'(bus.TGT_WE),   128'(0));
      chk("rd_addr", 128'(bus.TGT_ADDR), 128'(32'h10));
      held = 0;
      repeat (3) begin
         step(1);
         if (bus.TGT_REQ == 4'b0100) held++;
      end
      chk("rd_req_held", 128'(held), 128'(3));
      bus.TGT_RDATA[2*64 +: 64] = 64'hDEADBEEF_01234567;
      bus.TGT_ACK = 4'b0100;
      step(1);
      bus.TGT_ACK = '0;
      chk("rd_req_drop", 128'(bus.TGT_REQ), 128'(0));
      finish_txn("rd");

      // WRITE target 0 with zero-wait ack; cycle-accurate latency.
      push_stat(8'h80);
      issue(mk(8'h02, 8'd0, 32'h2000_0040, 64'hA5A5A5A5_A5A5A5A5));
      step(1);
      chk("wr_decode_busy", 128'(bus.BUSY),    128'(1));
      chk("wr_decode_req",  128'(bus.TGT_REQ), 128'(0));
      step(1);
      chk("wr_req",   128'(bus.TGT_REQ),   128'(4'b0001));
      chk("wr_we",    128'(bus.TGT_WE),    128'(1));
      chk("wr_addr",  128'(bus.TGT_ADDR),  128'(32'h2000_0040));
      chk("wr_wdata", 128'(bus.TGT_WDATA), 128'(64'hA5A5A5A5_A5A5A5A5));
      bus.TGT_ACK = 4'b0001;
      step(1);
      bus.TGT_ACK = '0;
      chk("wr_req_drop",   128'(bus.TGT_REQ),    128'(0));
      chk("wr_valid_early",128'(bus.DATA_VALID), 128'(0));
      step(1);
      chk("wr_stat_valid", 128'(bus.DATA_VALID),  128'(1));
      chk("wr_stat_bank",  128'(bus.DATA_OFFSET), 128'(2'b10));
      finish_txn("wr");

      // Target out of range, then illegal opcode.
      push_stat(8'h82);
      issue(mk(8'h01, 8'd5, 32'h0, 64'h0));
      seen = 1'b0;
      repeat (8) begin
         step(1);
         seen |= (bus.TGT_REQ != '0);
      end
      chk("badtgt_no_req", 128'(seen), 128'(0));
      finish_txn("badtgt");

      push_stat(8'h83);
      issue(mk(8'h07, 8'd1, 32'h0, 64'h0));
      seen = 1'b0;
      repeat (8) begin
         step(1);
         seen |= (bus.TGT_REQ != '0);
      end
      chk("badop_no_req", 128'(seen), 128'(0));
      finish_txn("badop");

      // No ack: request held exactly TIMEOUT cycles, late ack ignored.
      push_stat(8'h81);
      issue(mk(8'h01, 8'd1, 32'h44, 64'h0));
      wait_req("to");
      cnt = 0;
      while (bus.TGT_REQ != '0 && cnt < 100) begin
         cnt++;
         step(1);
      end
      chk("to_req_cycles", 128'(cnt), 128'(TO));
      bus.TGT_RDATA[1*64 +: 64] = 64'h1111_2222_3333_4444;
      bus.TGT_ACK = 4'b0010;
      step(1);
      bus.TGT_ACK = '0;
      finish_txn("to");

      // Level held high: one transaction; a fresh rising edge gives another.
      push_stat(8'h80);
      issue(mk(8'h02, 8'd3, 32'h80, 64'h5555));
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (bus.TGT_REQ != '0 && !prev) rises++;
         prev = (bus.TGT_REQ != '0);
         bus.TGT_ACK = bus.TGT_REQ[3] ? 4'b1000 : 4'b0000;
      end
      bus.TGT_ACK = '0;
      chk("lvl_one_txn",   128'(rises),    128'(1));
      chk("lvl_busy_held", 128'(bus.BUSY), 128'(1));
      bus.COMM_VALID = 1'b0;
      step(3);
      chk("lvl_busy_low", 128'(bus.BUSY), 128'(0));
      push_stat(8'h80);
      bus.COMM_VALID = 1'b1;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.TGT_REQ != '0 && !prev) rises++;
         prev = (bus.TGT_REQ != '0);
         bus.TGT_ACK = bus.TGT_REQ[3] ? 4'b1000 : 4'b0000;
      end
      bus.TGT_ACK = '0;
      chk("lvl_second_txn", 128'(rises), 128'(1));
      finish_txn("lvl");

      // Reset during REQ aborts without writeback; next command completes.
      issue(mk(8'h01, 8'd0, 32'h8, 64'h0));
      wait_req("rst");
      RST = 1'b1;
      bus.COMM_VALID = 1'b0;
      step(1);
      chk("rst_mid_req",   128'(bus.TGT_REQ),    128'(0));
      chk("rst_mid_valid", 128'(bus.DATA_VALID), 128'(0));
      chk("rst_mid_busy",  128'(bus.BUSY),       128'(0));
      RST = 1'b0;
      step(2);
      push_data(64'h01234567_89ABCDEF);
      push_stat(8'h80);
      issue(mk(8'h01, 8'd3, 32'h40, 64'h0));
      wait_req("post");
      chk("post_req", 128'(bus.TGT_REQ), 128'(4'b1000));
      bus.TGT_RDATA[3*64 +: 64] = 64'h01234567_89ABCDEF;
      bus.TGT_ACK = 4'b1000;
      step(1);
      bus.TGT_ACK = '0;
      finish_txn("post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
